tt_um_quad_accumulator_gen: RTL and testbench
=============================================

// Module: tt_um_quad_accumulator_gen
// PURPOSE
//  Parametrised nonlinear accumulator: acc <= acc + (ui_in>>IN_SHIFT) + ((acc>>FB_SHIFT))^2 per step.
//  Square computed by an iterative shift-add multiplier. Adds linear mode, saturate/wrap, load, sticky overflow.
//  Tiny Tapeout user tile; uo_out drives the 7-seg/LED bank.
// PARAMETERS
//  WIDTH     8  accumulator width in bits (>=8)
//  IN_SHIFT  2  right shift applied to ui_in to form increment x (0..7)
//  FB_SHIFT  3  right shift applied to acc to form feedback f (0..WIDTH-1); M = WIDTH-FB_SHIFT
// PORTS
//  clk      in   1  clock
//  rst_n    in   1  synchronous active-low reset
//  ena      in   1  tile enable; low = freeze all state (reset still acts)
//  ui_in    in   8  increment source / load value
//  uio_in   in   8  [0] run, [1] mode (1=quadratic, 0=linear), [2] sat (1=saturate, 0=wrap), [3] load; [7:4] unused
//  uo_out   out  8  acc[WIDTH-1 -: 8]
//  uio_out  out  8  [4] busy, [5] ovf (sticky), [6] step_done, [7] sat_hit; [3:0] = 0
//  uio_oe   out  8  constant 8'hF0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, acc=0, ovf=0, step_done=0, sat_hit=0, mult regs=0.
//  ena=0: no register changes except reset; outputs hold.
//  FSM: IDLE, MUL, ACC.
//   IDLE: load=1 -> acc<=zero-extended ui_in, ovf<=0, stay IDLE (load beats run).
//         else run=1 -> capture x=ui_in>>IN_SHIFT, f=acc>>FB_SHIFT, mode, sat; prod=0, cnt=0;
//         -> MUL if mode=1, -> ACC if mode=0.
//   MUL:  one multiplier bit per cycle (prod += f<<cnt when f[cnt]); exactly M cycles, then -> ACC.
//   ACC:  sum = acc + x + (mode ? prod : 0), sum width max(WIDTH,2M)+1, no truncation before compare.
//         sum >= 2^WIDTH: ovf<=1; sat ? acc<=all-ones, sat_hit<=1 : acc<=sum[WIDTH-1:0], sat_hit<=0.
//         else acc<=sum, sat_hit<=0. -> IDLE.
//  step_done: registered 1-cycle pulse, high in the cycle after ACC (same cycle new acc is visible).
//  busy = (state!=IDLE). run held high -> back-to-back steps; period M+2 cycles (quadratic), 2 (linear).
//  ui_in/uio_in changes while busy are ignored (operands and mode/sat captured at IDLE exit).
//  load/run while busy ignored (not queued). Reset mid-MUL/ACC aborts step; acc=0, no step_done.
//  ovf cleared only by reset or load. Quadratic+wrap with defaults == acc+ui_in/4+(acc/8)^2 mod 256.
// STRUCTURE
//  Package tt_qacc_pkg: state enum {IDLE,MUL,ACC}; uio bit index localparams (RUN,MODE,SAT,LOAD,
//   BUSY,OVF,DONE,SATHIT); function clog2 for cnt width.
//  Sub-module tt_seq_mult: M-bit x M-bit shift-add multiplier, start/done handshake, 2M-bit product.
//  Top: FSM + accumulator + saturation compare + status regs.
// TESTING (WIDTH=8, IN_SHIFT=2, FB_SHIFT=3, M=5)
//  Reset, then run=1, mode=1, sat=0, ui_in=40 -> acc 10,21,35,61 on successive step_done; ovf=0.
//  Latency: run pulse in IDLE, quadratic -> step_done exactly 7 cycles later, busy high 6 cycles;
//   linear -> step_done 2 cycles later.
//  load ui_in=200, then quadratic step ui_in=0 sat=1 -> acc=255, ovf=1, sat_hit=1; repeat with sat=0 -> acc=57.
//  load 250, linear wrap ui_in=40 -> acc=4, ovf=1; load 0 -> ovf=0; load+run same cycle -> load only.
//  ena=0 mid-MUL for 10 cycles -> state/acc frozen, step result identical to uninterrupted run.
//  rst_n=0 during MUL -> next cycle acc=0, busy=0, no step_done; ui_in/mode change mid-MUL -> no effect.

Source files
------------

// File: rtl/tt_qacc_pkg.sv
// Shared types and constants for the quadratic accumulator tile.
package tt_qacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  // uio_in control bits
  localparam int RUN    = 0;
  localparam int MODE   = 1;
  localparam int SAT    = 2;
  localparam int LOAD   = 3;
  // uio_out status bits
  localparam int BUSY   = 4;
  localparam int OVF    = 5;
  localparam int DONE   = 6;
  localparam int SATHIT = 7;

  // Never returns less than 1 so counters always have at least one bit
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tt_seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per enabled cycle, M cycles per product.
module tt_seq_mult
  import tt_qacc_pkg::*;
#(
  parameter int M = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [2*M-1:0] prod,
  output logic           done
);

  localparam int CW = clog2(M);

  logic [2*M-1:0] a_r;
  logic [M-1:0]   b_r;
  logic [CW-1:0]  cnt;
  logic           running;

  // done flags the cycle in which the last partial product is being added
  assign done = running && (cnt == CW'(M - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      cnt     <= '0;
      prod    <= '0;
      running <= 1'b0;
    end else if (ena) begin
      if (start) begin
        a_r     <= (2*M)'(a);
        b_r     <= b;
        cnt     <= '0;
        prod    <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (b_r[cnt]) prod <= prod + (a_r << cnt);
        cnt <= cnt + CW'(1);
        if (done) running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tt_um_quad_accumulator_gen.sv
// Tiny Tapeout tile: accumulator stepping acc + x (+ f^2 in quadratic mode) with saturate/wrap.
module tt_um_quad_accumulator_gen
  import tt_qacc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IN_SHIFT = 2,
  parameter int FB_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int M  = WIDTH - FB_SHIFT;
  localparam int SW = ((WIDTH > 2*M) ? WIDTH : 2*M) + 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [7:0]       x;
  logic             mode_r, sat_r, ovf, step_done, sat_hit, busy;
  logic [M-1:0]     f;
  logic [2*M-1:0]   prod;
  logic             mult_start, mult_done;
  logic [SW-1:0]    sum;
  logic             overflow;
  logic             run, load;
  logic             unused_uio;

  assign run        = uio_in[RUN];
  assign load       = uio_in[LOAD];
  assign unused_uio = &{1'b0, uio_in[7:4]};
  assign f          = acc[WIDTH-1:FB_SHIFT];
  assign mult_start = (state == IDLE) && !load && run && uio_in[MODE];

  tt_seq_mult #(.M(M)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (mult_start),
    .a     (f),
    .b     (f),
    .prod  (prod),
    .done  (mult_done)
  );

  // Full-width sum so overflow is judged before any truncation
  assign sum      = SW'(acc) + SW'(x) + (mode_r ? SW'(prod) : '0);
  assign overflow = |sum[SW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!load && run) state_next = uio_in[MODE] ? MUL : ACC;
      MUL:     if (mult_done)    state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      x         <= '0;
      mode_r    <= 1'b0;
      sat_r     <= 1'b0;
      ovf       <= 1'b0;
      step_done <= 1'b0;
      sat_hit   <= 1'b0;
    end else if (ena) begin
      step_done <= (state == ACC);
      case (state)
        IDLE: begin
          if (load) begin
            acc <= WIDTH'(ui_in);
            ovf <= 1'b0;
          end else if (run) begin
            x      <= ui_in >> IN_SHIFT;
            mode_r <= uio_in[MODE];
            sat_r  <= uio_in[SAT];
          end
        end
        ACC: begin
          if (overflow) begin
            ovf     <= 1'b1;
            acc     <= sat_r ? '1 : sum[WIDTH-1:0];
            sat_hit <= sat_r;
          end else begin
            acc     <= sum[WIDTH-1:0];
            sat_hit <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = acc[WIDTH-1 -: 8];
  assign uio_out = {sat_hit, step_done, ovf, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_quad_accumulator_gen.sv
// Directed bench for the quadratic accumulator tile at default parameters (M = 5).
module tb_tt_um_quad_accumulator_gen;
  import tt_qacc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  tt_um_quad_accumulator_gen #(
    .WIDTH    (8),
    .IN_SHIFT (2),
    .FB_SHIFT (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    ui_in        = v;
    uio_in       = '0;
    uio_in[LOAD] = 1'b1;
    tick();
    uio_in = '0;
  endtask

  // Issues a single run pulse and waits (bounded) for step_done
  task automatic do_step(input logic mode, input logic sat, input logic [7:0] ui,
                         input int freeze_at, input logic disturb,
                         output int lat, output int busy_n);
    logic [7:0] held;
    ui_in        = ui;
    uio_in       = '0;
    uio_in[RUN]  = 1'b1;
    uio_in[MODE] = mode;
    uio_in[SAT]  = sat;
    tick();
    lat         = 1;
    busy_n      = 0;
    uio_in[RUN] = 1'b0;
    while (!uio_out[DONE] && lat < 60) begin
      if (uio_out[BUSY]) busy_n++;
      if (disturb && lat == 2) begin
        ui_in        = 8'hFF;
        uio_in[MODE] = ~mode;
        uio_in[SAT]  = ~sat;
      end
      if (freeze_at != 0 && lat == freeze_at) begin
        held = uo_out;
        ena  = 1'b0;
        repeat (10) tick();
        lat += 10;
        check("freeze_acc", uo_out, held);
        check("freeze_busy", uio_out[BUSY], 1);
        ena = 1'b1;
      end
      tick();
      lat++;
    end
    if (!uio_out[DONE]) check("step_timeout", 0, 1);
  endtask

  initial begin
    int lat, busy_n, dones, last_t, t;
    logic saw_done;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    repeat (3) tick();
    check("rst_acc", uo_out, 0);
    check("rst_status", uio_out, 0);
    check("uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();

    // Run held high: quadratic wrap steps 0 -> 10 -> 21 -> 35 -> 61
    ui_in        = 8'd40;
    uio_in       = '0;
    uio_in[RUN]  = 1'b1;
    uio_in[MODE] = 1'b1;
    dones  = 0;
    t      = 0;
    last_t = 0;
    while (dones < 4 && t < 100) begin
      tick();
      t++;
      if (uio_out[DONE]) begin
        case (dones)
          0: check("seq_acc0", uo_out, 10);
          1: check("seq_acc1", uo_out, 21);
          2: check("seq_acc2", uo_out, 35);
          default: check("seq_acc3", uo_out, 61);
        endcase
        if (dones > 0) check("seq_period", t - last_t, 7);
        last_t = t;
        dones++;
        if (dones == 4) uio_in[RUN] = 1'b0;
      end
    end
    check("seq_count", dones, 4);
    check("seq_ovf", uio_out[OVF], 0);

    // Latency: quadratic from 61 with x=0 -> 61+49=110; linear +10 -> 120
    do_step(1'b1, 1'b0, 8'd0, 0, 1'b0, lat, busy_n);
    check("quad_lat", lat, 7);
    check("quad_busy", busy_n, 6);
    check("quad_acc", uo_out, 110);
    do_step(1'b0, 1'b0, 8'd40, 0, 1'b0, lat, busy_n);
    check("lin_lat", lat, 2);
    check("lin_acc", uo_out, 120);

    // Saturation: 200 + 25^2 = 825
    do_load(8'd200);
    check("load200", uo_out, 200);
    do_step(1'b1, 1'b1, 8'd0, 0, 1'b0, lat, busy_n);
    check("sat_acc", uo_out, 255);
    check("sat_ovf", uio_out[OVF], 1);
    check("sat_hit", uio_out[SATHIT], 1);
    do_load(8'd200);
    check("load_clr_ovf", uio_out[OVF], 0);
    do_step(1'b1, 1'b0, 8'd0, 0, 1'b0, lat, busy_n);
    check("wrap_acc", uo_out, 57);
    check("wrap_ovf", uio_out[OVF], 1);
    check("wrap_sathit", uio_out[SATHIT], 0);

    // Linear wrap 250 + 10 -> 4
    do_load(8'd250);
    do_step(1'b0, 1'b0, 8'd40, 0, 1'b0, lat, busy_n);
    check("lin_wrap_acc", uo_out, 4);
    check("lin_wrap_ovf", uio_out[OVF], 1);
    do_load(8'd0);
    check("load0_ovf", uio_out[OVF], 0);
    check("load0_acc", uo_out, 0);

    // Load and run together: load wins, no step starts
    ui_in        = 8'd7;
    uio_in       = '0;
    uio_in[LOAD] = 1'b1;
    uio_in[RUN]  = 1'b1;
    uio_in[MODE] = 1'b1;
    tick();
    uio_in = '0;
    check("loadrun_acc", uo_out, 7);
    check("loadrun_busy", uio_out[BUSY], 0);
    saw_done = 1'b0;
    repeat (8) begin
      tick();
      if (uio_out[DONE]) saw_done = 1'b1;
    end
    check("loadrun_nodone", saw_done, 0);
    check("loadrun_hold", uo_out, 7);

    // Freeze mid-MUL: 8 + 10 + 1 = 19, latency stretched by 10
    do_load(8'd8);
    do_step(1'b1, 1'b0, 8'd40, 3, 1'b0, lat, busy_n);
    check("freeze_result", uo_out, 19);
    check("freeze_lat", lat, 17);

    // Inputs disturbed while busy have no effect
    do_load(8'd8);
    do_step(1'b1, 1'b0, 8'd40, 0, 1'b1, lat, busy_n);
    check("disturb_result", uo_out, 19);
    check("disturb_lat", lat, 7);

    // Reset during MUL aborts the step
    do_load(8'd100);
    ui_in        = 8'd40;
    uio_in       = '0;
    uio_in[RUN]  = 1'b1;
    uio_in[MODE] = 1'b1;
    tick();
    uio_in = '0;
    tick();
    tick();
    check("pre_rst_busy", uio_out[BUSY], 1);
    rst_n = 1'b0;
    tick();
    check("midrst_acc", uo_out, 0);
    check("midrst_busy", uio_out[BUSY], 0);
    check("midrst_done", uio_out[DONE], 0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      tick();
      if (uio_out[DONE]) saw_done = 1'b1;
    end
    check("midrst_nodone", saw_done, 0);
    check("midrst_acc_hold", uo_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
